// File: rtl/stopwatch_core_pkg.sv
// rtl/stopwatch_core_pkg.sv - shared types, digit limits and segment table for the stopwatch core
package stopwatch_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_FULL  = 2'd3
  } sw_state_t;

  typedef struct packed {
    logic [3:0] m;
    logic [3:0] s10;
    logic [3:0] s1;
    logic [3:0] t;
  } sw_time_t;

  localparam logic [3:0] T_MAX   = 4'd9;
  localparam logic [3:0] S1_MAX  = 4'd9;
  localparam logic [3:0] S10_MAX = 4'd5;
  localparam logic [3:0] M_MAX   = 4'd9;

  // Scan index of each digit; the decimal point follows the seconds and minutes digits.
  localparam logic [1:0] IDX_T     = 2'd0;
  localparam logic [1:0] IDX_S1    = 2'd1;
  localparam logic [1:0] IDX_S10   = 2'd2;
  localparam logic [1:0] IDX_M     = 2'd3;
  localparam logic [1:0] DP_IDX_S1 = IDX_S1;
  localparam logic [1:0] DP_IDX_M  = IDX_M;

  // {g,f,e,d,c,b,a} codes, entry [n] is digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam sw_time_t TIME_ZERO = '{m: 4'd0, s10: 4'd0, s1: 4'd0, t: 4'd0};
  localparam sw_time_t TIME_MAX  = '{m: M_MAX, s10: S10_MAX, s1: S1_MAX, t: T_MAX};

  function automatic sw_time_t bcd_increment(input sw_time_t v);
    sw_time_t r;
    r = v;
    if (v.t != T_MAX) begin
      r.t = v.t + 4'd1;
    end else begin
      r.t = 4'd0;
      if (v.s1 != S1_MAX) begin
        r.s1 = v.s1 + 4'd1;
      end else begin
        r.s1 = 4'd0;
        if (v.s10 != S10_MAX) begin
          r.s10 = v.s10 + 4'd1;
        end else begin
          r.s10 = 4'd0;
          r.m   = v.m + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_core_bcd_to_7seg.sv
// rtl/stopwatch_core_bcd_to_7seg.sv - combinational BCD to 7-segment decoder, non-decimal codes blank
module bcd_to_7seg
  import stopwatch_core_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segments
);

  always_comb begin
    segments = 7'h00;
    if (bcd <= 4'd9) segments = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - M:SS.T stopwatch with start/pause/clear keys and multiplexed 4-digit display
module stopwatch_core
  import stopwatch_core_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst,
  input  logic       clk_1kHz,
  input  logic       clk_10Hz,
  input  logic       key_start,
  input  logic       key_clear,
  output logic [7:0] seg,
  output logic [3:0] digit_sel,
  output logic       running,
  output logic       full
);

  localparam int P_1K    = 0;
  localparam int P_10    = 1;
  localparam int P_START = 2;
  localparam int P_CLEAR = 3;

  logic [3:0] raw_in;
  logic [3:0] sync1, sync2, sync2_d, armed, pulse;
  logic [1:0] warm;
  logic       warm_done;

  logic       tick_1k, tick_10, start_p, clear_p;
  sw_state_t  state;
  sw_time_t   value;
  logic [1:0] scan_idx;
  logic [3:0] cur_digit;
  logic [6:0] seg_code;
  logic       dp;

  assign raw_in    = {key_clear, key_start, clk_10Hz, clk_1kHz};
  assign warm_done = (warm == 2'd2);

  // An edge only arms after sync2 has held a real (post-reset) low, so a level
  // that is already high when reset drops does not fire.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1   <= 4'b0;
      sync2   <= 4'b0;
      sync2_d <= 4'b0;
      armed   <= 4'b0;
      pulse   <= 4'b0;
      warm    <= 2'd0;
    end else begin
      sync1   <= raw_in;
      sync2   <= sync1;
      sync2_d <= sync2;
      if (!warm_done) warm <= warm + 2'd1;
      armed   <= armed | (~sync2 & {4{warm_done}});
      pulse   <= armed & sync2 & ~sync2_d;
    end
  end

  assign tick_1k = pulse[P_1K];
  assign tick_10 = pulse[P_10];
  assign start_p = pulse[P_START];
  assign clear_p = pulse[P_CLEAR];

  always_comb begin
    case (scan_idx)
      IDX_T:   cur_digit = value.t;
      IDX_S1:  cur_digit = value.s1;
      IDX_S10: cur_digit = value.s10;
      default: cur_digit = value.m;
    endcase
  end

  assign dp = (scan_idx == DP_IDX_S1) || (scan_idx == DP_IDX_M);

  bcd_to_7seg u_bcd_to_7seg (
    .bcd      (cur_digit),
    .segments (seg_code)
  );

  // Priority clear > start > tick; a tick arriving with start is dropped.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= ST_IDLE;
      value     <= TIME_ZERO;
      scan_idx  <= IDX_T;
      seg       <= 8'h3F;
      digit_sel <= 4'b0001;
    end else begin
      if (tick_1k) scan_idx <= scan_idx + 2'd1;
      seg       <= {dp, seg_code};
      digit_sel <= 4'b0001 << scan_idx;

      if (clear_p) begin
        state <= ST_IDLE;
        value <= TIME_ZERO;
      end else if (start_p) begin
        case (state)
          ST_IDLE:  state <= ST_RUN;
          ST_RUN:   state <= ST_PAUSE;
          ST_PAUSE: state <= ST_RUN;
          default:  state <= ST_FULL;
        endcase
      end else if (tick_10 && state == ST_RUN) begin
        if (value == TIME_MAX) state <= ST_FULL;
        else                   value <= bcd_increment(value);
      end
    end
  end

  assign running = (state == ST_RUN);
  assign full    = (state == ST_FULL);

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - randomized self-checking bench for stopwatch_core
module tb_stopwatch_core;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       clk_1kHz = 1'b0;
  logic       clk_10Hz = 1'b0;
  logic       key_start = 1'b0;
  logic       key_clear = 1'b0;
  logic [7:0] seg;
  logic [3:0] digit_sel;
  logic       running;
  logic       full;

  stopwatch_core dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .clk_1kHz  (clk_1kHz),
    .clk_10Hz  (clk_10Hz),
    .key_start (key_start),
    .key_clear (key_clear),
    .seg       (seg),
    .digit_sel (digit_sel),
    .running   (running),
    .full      (full)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: time as a count of tenths, state 0=idle 1=run 2=pause 3=full.
  int m_val = 0;
  int m_st = 0;
  int m_idx = 0;

  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [7:0] want_1234 [4] = '{8'h66, 8'hCF, 8'h5B, 8'h86};
  logic [7:0] cap_seg [4];
  logic [3:0] cap_sel [4];

  function automatic logic [7:0] exp_seg(input int val, input int i);
    int sec, d;
    sec = val / 10;
    case (i)
      0:       d = val % 10;
      1:       d = sec % 10;
      2:       d = (sec / 10) % 6;
      default: d = sec / 60;
    endcase
    return {((i == 1) || (i == 3)) ? 1'b1 : 1'b0, seg_tbl[d]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic m_apply(input bit s, input bit c, input bit t);
    if (c) begin
      m_val = 0;
      m_st  = 0;
    end else if (s) begin
      case (m_st)
        0: m_st = 1;
        1: m_st = 2;
        2: m_st = 1;
        default: ;
      endcase
    end else if (t && m_st == 1) begin
      if (m_val == 5999) m_st = 3;
      else m_val++;
    end
  endtask

  task automatic ev(input bit s, input bit c, input bit t);
    key_start = s;
    key_clear = c;
    clk_10Hz  = t;
    cyc(3);
    key_start = 1'b0;
    key_clear = 1'b0;
    clk_10Hz  = 1'b0;
    cyc(3);
    m_apply(s, c, t);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) ev(1'b0, 1'b0, 1'b1);
  endtask

  task automatic read_display();
    for (int k = 0; k < 4; k++) begin
      clk_1kHz = 1'b1;
      cyc(3);
      clk_1kHz = 1'b0;
      cyc(3);
      m_idx = (m_idx + 1) % 4;
      cap_seg[m_idx] = seg;
      cap_sel[m_idx] = digit_sel;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cyc(n);
    rst = 1'b0;
    m_val = 0;
    m_st  = 0;
    m_idx = 0;
  endtask

  task automatic test_reset();
    do_reset(2);
    n_chk++; if (seg !== 8'h3F) $display("FAIL reset_seg got %h want 3f", seg); else n_pass++;
    n_chk++; if (digit_sel !== 4'b0001) $display("FAIL reset_sel got %b want 0001", digit_sel); else n_pass++;
    n_chk++; if (running !== 1'b0) $display("FAIL reset_running got %b want 0", running); else n_pass++;
    n_chk++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
    cyc(4);
  endtask

  task automatic test_pause_hold();
    ev(1, 0, 0);
    ticks(25);
    ev(1, 0, 0);
    read_display();
    n_chk++; if (running !== 1'b0 || m_val != 25) $display("FAIL pause_state running %b want 0 (model %0d)", running, m_val); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (cap_seg[i] !== exp_seg(25, i) || cap_sel[i] !== (4'b0001 << i))
        $display("FAIL pause_digit%0d got %b/%h want %b/%h", i, cap_sel[i], cap_seg[i], 4'b0001 << i, exp_seg(25, i));
      else n_pass++;
    end
    ticks(10);
    read_display();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (cap_seg[i] !== exp_seg(25, i))
        $display("FAIL pause_hold_digit%0d got %h want %h", i, cap_seg[i], exp_seg(25, i));
      else n_pass++;
    end
  endtask

  task automatic test_carry_full();
    ev(0, 1, 0);
    ev(1, 0, 0);
    ticks(599);
    ticks(1);
    read_display();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (cap_seg[i] !== exp_seg(600, i))
        $display("FAIL carry_1m_digit%0d got %h want %h", i, cap_seg[i], exp_seg(600, i));
      else n_pass++;
    end
    ticks(5999 - 600);
    ticks(1);
    n_chk++; if (full !== 1'b1 || running !== 1'b0) $display("FAIL full_enter got full=%b running=%b want 1/0", full, running); else n_pass++;
    read_display();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (cap_seg[i] !== exp_seg(5999, i))
        $display("FAIL full_hold_digit%0d got %h want %h", i, cap_seg[i], exp_seg(5999, i));
      else n_pass++;
    end
    ev(1, 0, 0);
    n_chk++; if (full !== 1'b1 || running !== 1'b0) $display("FAIL full_ignore_start got full=%b running=%b want 1/0", full, running); else n_pass++;
  endtask

  task automatic test_coincide();
    ev(0, 1, 0);
    n_chk++; if (full !== 1'b0 || running !== 1'b0) $display("FAIL clear_from_full got full=%b running=%b want 0/0", full, running); else n_pass++;
    ev(1, 0, 0);
    ticks(3);
    ev(1, 0, 1);
    n_chk++; if (running !== 1'b0) $display("FAIL start_tick_pause got running=%b want 0", running); else n_pass++;
    read_display();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (cap_seg[i] !== exp_seg(3, i))
        $display("FAIL start_tick_digit%0d got %h want %h", i, cap_seg[i], exp_seg(3, i));
      else n_pass++;
    end
    ev(1, 1, 0);
    n_chk++; if (running !== 1'b0 || full !== 1'b0) $display("FAIL clear_start got running=%b full=%b want 0/0", running, full); else n_pass++;
    ev(1, 0, 0);
    n_chk++; if (running !== 1'b1) $display("FAIL after_clear_start got running=%b want 1 (idle->run)", running); else n_pass++;
    ev(0, 1, 0);
    read_display();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (cap_seg[i] !== exp_seg(0, i))
        $display("FAIL clear_digit%0d got %h want %h", i, cap_seg[i], exp_seg(0, i));
      else n_pass++;
    end
  endtask

  task automatic test_scan();
    ev(1, 0, 0);
    ticks(834);
    ev(1, 0, 0);
    read_display();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (cap_sel[i] !== (4'b0001 << i) || cap_seg[i] !== want_1234[i])
        $display("FAIL scan_1234_idx%0d got %b/%h want %b/%h", i, cap_sel[i], cap_seg[i], 4'b0001 << i, want_1234[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run();
    ev(0, 1, 0);
    ev(1, 0, 0);
    ticks(77);
    do_reset(1);
    n_chk++; if (running !== 1'b0 || full !== 1'b0) $display("FAIL rst_run_flags got running=%b full=%b want 0/0", running, full); else n_pass++;
    n_chk++; if (seg !== 8'h3F || digit_sel !== 4'b0001) $display("FAIL rst_run_outputs got %h/%b want 3f/0001", seg, digit_sel); else n_pass++;
    cyc(4);
    read_display();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (cap_seg[i] !== exp_seg(0, i))
        $display("FAIL rst_run_digit%0d got %h want %h", i, cap_seg[i], exp_seg(0, i));
      else n_pass++;
    end
    key_start = 1'b1;
    do_reset(2);
    cyc(10);
    n_chk++; if (running !== 1'b0) $display("FAIL held_key_no_pulse got running=%b want 0", running); else n_pass++;
    key_start = 1'b0;
    cyc(4);
    ev(1, 0, 0);
    n_chk++; if (running !== 1'b1) $display("FAIL held_key_rearm got running=%b want 1", running); else n_pass++;
  endtask

  task automatic test_random();
    int r;
    ev(0, 1, 0);
    ev(1, 0, 0);
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      ev(0, 0, 1);
      else if (r <= 7) ev(1, 0, 0);
      else if (r == 8) ev(0, 1, 0);
      else             ev(1, 0, 1);
      n_chk++;
      if (running !== (m_st == 1) || full !== (m_st == 3))
        $display("FAIL rand_state_it%0d got running=%b full=%b want %b/%b", it, running, full, m_st == 1, m_st == 3);
      else n_pass++;
      if (it % 10 == 9) begin
        read_display();
        for (int i = 0; i < 4; i++) begin
          n_chk++;
          if (cap_seg[i] !== exp_seg(m_val, i))
            $display("FAIL rand_digit%0d_it%0d got %h want %h", i, it, cap_seg[i], exp_seg(m_val, i));
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    cyc(1);
    test_reset();
    test_pause_hold();
    test_carry_full();
    test_coincide();
    test_scan();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have one clock, clk_in (1 MHz); reset is synchronous and active-high, port rst.
REQ-002 Ports (name  direction  width  meaning):
 clk_in  in  1  system clock, 1 MHz, sole clock of the block
 rst  in  1  synchronous active-high reset (keypad_0)
 clk_1kHz  in  1  1 kHz square wave from the divider, sampled as data
 clk_10Hz  in  1  10 Hz square wave from the divider, sampled as data
 key_start  in  1  start/pause key level, debounced, asynchronous to clk_in
 key_clear  in  1  clear key level, debounced, asynchronous to clk_in
 seg  out  8  segment drive {dp,g,f,e,d,c,b,a}, active-high
 digit_sel  out  4  one-hot digit enable, active-high, bit0 = rightmost digit
 running  out  1  high while the FSM is in RUN
 full  out  1  high while the FSM is in FULL
REQ-003 SHALL use no clk_1kHz or clk_10Hz edge as a clock; all flops SHALL be clocked by clk_in only.

Function
REQ-004 Each of clk_1kHz, clk_10Hz, key_start and key_clear SHALL pass through a 2-flop synchronizer followed by a rising-edge detector producing a one-clk_in-cycle pulse (tick_1k, tick_10, start_p, clear_p).
REQ-005 Pulse latency: a pulse SHALL be high in the 3rd clk_in cycle after the input is first sampled high; the affected register SHALL update at the end of that cycle.
REQ-006 Time value: four BCD digits M (0-9), S10 (0-5), S1 (0-9), T (0-9) = M:SS.T, range 0:00.0 to 9:59.9.
REQ-007 FSM states: IDLE, RUN, PAUSE, FULL.
REQ-008 IDLE: start_p -> RUN; tick_10 ignored.
REQ-009 RUN: tick_10 increments T with ripple carry T(9->0) -> S1(9->0) -> S10(5->0) -> M; start_p -> PAUSE.
REQ-010 RUN with value 9:59.9 and tick_10: value SHALL hold 9:59.9 and FSM -> FULL (no wrap).
REQ-011 PAUSE: value held; start_p -> RUN; tick_10 ignored.
REQ-012 FULL: value held at 9:59.9; start_p ignored.
REQ-013 clear_p in any state SHALL zero all digits and go to IDLE at end of that cycle.
REQ-014 Simultaneous events priority: clear_p > start_p > tick_10; a tick coinciding with start_p SHALL NOT be counted in any state.
REQ-015 Display scan: 2-bit index SHALL advance 0->1->2->3->0 on each tick_1k; index 0=T, 1=S1, 2=S10, 3=M.
REQ-016 seg and digit_sel SHALL be registered and update one clk_in cycle after the index changes; digit_sel = one-hot of index.
REQ-017 seg[6:0] = standard 7-seg code of the selected digit (0 = 7'h3F, 1 = 7'h06, 9 = 7'h6F); seg[7] (dp) SHALL be 1 when S1 or M is selected, else 0.
REQ-018 running and full SHALL be decoded from the registered state (no extra latency beyond the state register).

Reset
REQ-019 On rst high at a clk_in edge: state IDLE, all digits 0, scan index 0, all synchronizer and edge flops 0.
REQ-020 Output reset values: seg = 8'h3F, digit_sel = 4'b0001, running = 0, full = 0.
REQ-021 rst SHALL override all other inputs, including mid-count in RUN and in FULL.
REQ-022 An input already high when rst deasserts SHALL NOT produce a pulse until it goes low and high again.

Structure
REQ-023 Shared package SHALL hold: FSM state encoding, digit limits (T/S1/M max 9, S10 max 5), the 10-entry 7-seg code table, dp digit indices.
REQ-024 One sub-module SHALL be used: bcd_to_7seg (4-bit BCD in, 7-bit segment code out, combinational, codes 10-15 -> all off).

Verification
REQ-025 Reset: rst high 2 cycles -> seg=8'h3F, digit_sel=4'b0001, running=0, full=0.
REQ-026 key_start pulse, 25 clk_10Hz rising edges, key_start pulse -> value 0:02.5, state PAUSE; 10 further clk_10Hz edges -> value still 0:02.5.
REQ-027 From 0:59.9 in RUN, one clk_10Hz edge -> 1:00.0; from 9:59.9 one edge -> 9:59.9, full=1, running=0; key_start -> still FULL.
REQ-028 key_start and clk_10Hz rising in the same sampled cycle in RUN at 0:00.3 -> PAUSE at 0:00.3; key_clear with key_start together -> IDLE, 0:00.0.
REQ-029 Scan with value 1:23.4: four clk_1kHz edges -> (digit_sel, seg) = (0001, 8'h66), (0010, 8'hCF), (0100, 8'h5B), (1000, 8'h86).
REQ-030 rst asserted during RUN at 0:07.7 -> next cycle value 0:00.0, IDLE, outputs at reset values.
